// File: rtl/msx_bus_master.sv
// ---------------------------------------------------------------------------
// msx_bus_master
//
// Initiator side of an MSX cartridge slot. Each accepted single-beat request
// becomes one Z80-style memory or I/O cycle on the slot. The cycle runs
// through address/select setup, the RD/WR strobe (stretched while the slot
// holds WAIT low), and address/data hold. It then returns read data, or a
// timeout flag if WAIT never released.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   req_*             request channel (valid/ready, single beat)
//   rsp_*             response: one-clock rsp_valid pulse with rdata/timeout
//   bus_addr          slot address A15..A0
//   bus_data_*        slot data bus (out, output enable, in)
//   sltsl_n, merq_n   slot select / memory request (memory cycles)
//   iorq_n            I/O request (I/O cycles)
//   rd_n, wr_n        read / write strobes
//   wait_n            asynchronous WAIT from the slot
//   busy              a bus cycle is in progress
// ---------------------------------------------------------------------------
module msx_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 1,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_io,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_data_in,
    output logic        sltsl_n,
    output logic        merq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    input  logic        wait_n,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_EXTEND = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    // Phase counts the clocks spent in the current state; a state ends on the
    // edge where the counter shows its last clock.
    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(WAIT_TIMEOUT - 1);

    logic [2:0] state_reg;
    logic [3:0] phase_reg;
    logic [7:0] wait_cnt_reg;
    logic       write_reg;
    logic       timeout_reg;
    logic       wait_meta_reg;
    logic       wait_s_reg;

    logic strobe_done;
    logic extend_ok;
    logic extend_expired;
    logic bus_release;

    // Only the last strobe clock looks at WAIT; earlier changes are ignored.
    always_comb begin
        strobe_done    = (state_reg == ST_STROBE) && (phase_reg == STROBE_LAST);
        extend_ok      = (state_reg == ST_EXTEND) && wait_s_reg;
        extend_expired = (state_reg == ST_EXTEND) && !wait_s_reg &&
                         (wait_cnt_reg == WAIT_LAST);
        bus_release    = (strobe_done && wait_s_reg) || extend_ok || extend_expired;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= 4'd0;
            wait_cnt_reg  <= 8'd0;
            write_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            wait_meta_reg <= 1'b1;
            wait_s_reg    <= 1'b1;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 8'hFF;
            rsp_timeout   <= 1'b0;
            bus_addr      <= 16'h0000;
            bus_data_out  <= 8'h00;
            bus_data_oe   <= 1'b0;
            sltsl_n       <= 1'b1;
            merq_n        <= 1'b1;
            iorq_n        <= 1'b1;
            rd_n          <= 1'b1;
            wr_n          <= 1'b1;
            busy          <= 1'b0;
        end else begin
            wait_meta_reg <= wait_n;
            wait_s_reg    <= wait_meta_reg;
            rsp_valid     <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_reg    <= ST_SETUP;
                        phase_reg    <= 4'd0;
                        wait_cnt_reg <= 8'd0;
                        write_reg    <= req_write;
                        timeout_reg  <= 1'b0;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        bus_addr     <= req_addr;
                        bus_data_oe  <= req_write;
                        if (req_write) begin
                            bus_data_out <= req_wdata;
                        end
                        sltsl_n      <= req_is_io;
                        merq_n       <= req_is_io;
                        iorq_n       <= !req_is_io;
                    end
                end
                ST_SETUP: begin
                    if (phase_reg == SETUP_LAST) begin
                        state_reg <= ST_STROBE;
                        phase_reg <= 4'd0;
                        rd_n      <= write_reg;
                        wr_n      <= !write_reg;
                    end else begin
                        phase_reg <= phase_reg + 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (!strobe_done) begin
                        phase_reg <= phase_reg + 4'd1;
                    end else if (!wait_s_reg) begin
                        state_reg    <= ST_EXTEND;
                        phase_reg    <= 4'd0;
                        wait_cnt_reg <= 8'd0;
                    end
                end
                ST_EXTEND: begin
                    if (!extend_ok && !extend_expired) begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (phase_reg == HOLD_LAST) begin
                        state_reg   <= ST_IDLE;
                        phase_reg   <= 4'd0;
                        bus_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= timeout_reg;
                    end else begin
                        phase_reg <= phase_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase

            // End of the strobe (normal or stretched): capture read data and
            // release every strobe and select together, then enter HOLD.
            if (bus_release) begin
                state_reg    <= ST_HOLD;
                phase_reg    <= 4'd0;
                wait_cnt_reg <= 8'd0;
                timeout_reg  <= extend_expired;
                if (!write_reg) begin
                    rsp_rdata <= extend_expired ? 8'hFF : bus_data_in;
                end
                sltsl_n <= 1'b1;
                merq_n  <= 1'b1;
                iorq_n  <= 1'b1;
                rd_n    <= 1'b1;
                wr_n    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msx_bus_master.sv
module tb_msx_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_io;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic [7:0]  bus_data_in;
    logic        sltsl_n, merq_n, iorq_n, rd_n, wr_n;
    logic        wait_n;
    logic        busy;

    // Second instance with a short WAIT timeout, WAIT stuck low.
    logic        t_req_valid;
    logic        t_req_ready;
    logic        t_rsp_valid;
    logic [7:0]  t_rsp_rdata;
    logic        t_rsp_timeout;
    logic [15:0] t_bus_addr;
    logic [7:0]  t_bus_data_out;
    logic        t_bus_data_oe;
    logic        t_sltsl_n, t_merq_n, t_iorq_n, t_rd_n, t_wr_n;
    logic        t_wait_n;
    logic        t_busy;

    always #5 clk = ~clk;

    msx_bus_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_io(req_is_io),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .bus_data_in(bus_data_in), .sltsl_n(sltsl_n), .merq_n(merq_n),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .wait_n(wait_n), .busy(busy)
    );

    msx_bus_master #(.WAIT_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_is_io(req_is_io),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_timeout(t_rsp_timeout),
        .bus_addr(t_bus_addr), .bus_data_out(t_bus_data_out), .bus_data_oe(t_bus_data_oe),
        .bus_data_in(bus_data_in), .sltsl_n(t_sltsl_n), .merq_n(t_merq_n),
        .iorq_n(t_iorq_n), .rd_n(t_rd_n), .wr_n(t_wr_n), .wait_n(t_wait_n), .busy(t_busy)
    );

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        timeout;
        logic [7:0]  lat;
        logic [7:0]  n_mem;
        logic [7:0]  n_io;
        logic [7:0]  n_rd;
        logic [7:0]  n_wr;
        logic [7:0]  n_oe;
        logic [7:0]  first_strb;
    } exp_t;

    exp_t cur_exp;
    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int acc_n   = 0;
    int last_rsp_cyc = 0;
    int m_mem, m_io, m_rd, m_wr, m_oe, m_first, m_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Acceptance tracker: pushes the expectation of the request being taken.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && req_valid && req_ready) begin
            sb.push_back(cur_exp);
            acc_cyc = cyc + 1;
            acc_n++;
            m_mem = 0; m_io = 0; m_rd = 0; m_wr = 0; m_oe = 0; m_first = 0; m_bad = 0;
            $display("accept  addr=%04h write=%0d io=%0d wdata=%02h at cycle %0d",
                     req_addr, req_write, req_is_io, req_wdata, cyc + 1);
        end
    end

    // Bus monitor and response checker.
    always @(negedge clk) begin
        int period;
        exp_t e;
        if (!reset) begin
            period = cyc - acc_cyc + 1;
            if (!sltsl_n && !merq_n) m_mem++;
            if (!iorq_n) m_io++;
            if (!rd_n) m_rd++;
            if (!wr_n) m_wr++;
            if (bus_data_oe) m_oe++;
            if ((!rd_n || !wr_n) && m_first == 0) m_first = period;
            if (sb.size() > 0) begin
                if ((!merq_n || !iorq_n) && bus_addr !== sb[0].addr) m_bad++;
                if (bus_data_oe && bus_data_out !== sb[0].wdata) m_bad++;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("rsp     addr=%04h rdata=%02h timeout=%0d period=%0d",
                             e.addr, rsp_rdata, rsp_timeout, period);
                    if (!e.write) check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
                    check("latency", 32'(period), 32'(e.lat));
                    check("mem_sel_clocks", 32'(m_mem), 32'(e.n_mem));
                    check("iorq_clocks", 32'(m_io), 32'(e.n_io));
                    check("rd_clocks", 32'(m_rd), 32'(e.n_rd));
                    check("wr_clocks", 32'(m_wr), 32'(e.n_wr));
                    check("oe_clocks", 32'(m_oe), 32'(e.n_oe));
                    check("first_strobe_period", 32'(m_first), 32'(e.first_strb));
                    check("addr_data_errors", 32'(m_bad), 32'd0);
                    check("idle_strobes", 32'({sltsl_n, merq_n, iorq_n, rd_n, wr_n, bus_data_oe}),
                          32'b111110);
                    last_rsp_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_accept();
        int start;
        bit ok;
        start = acc_n;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_n != start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rsp_wait_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic set_req(input logic io, input logic wr, input logic [15:0] a,
                           input logic [7:0] wd, input logic [7:0] rd, input logic [7:0] lat,
                           input logic [7:0] nsel, input logic [7:0] nstrb);
        req_is_io = io;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        cur_exp.write      = wr;
        cur_exp.addr       = a;
        cur_exp.wdata      = wd;
        cur_exp.rdata      = rd;
        cur_exp.timeout    = 1'b0;
        cur_exp.lat        = lat;
        cur_exp.n_mem      = io ? 8'd0 : nsel;
        cur_exp.n_io       = io ? nsel : 8'd0;
        cur_exp.n_rd       = wr ? 8'd0 : nstrb;
        cur_exp.n_wr       = wr ? nstrb : 8'd0;
        cur_exp.n_oe       = wr ? nsel + 8'd1 : 8'd0;
        cur_exp.first_strb = 8'd2;
    endtask

    initial begin
        int per, cnt, nrsp, acc1;
        reset       = 1'b1;
        req_valid   = 1'b0;
        t_req_valid = 1'b0;
        req_is_io   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 16'h0;
        req_wdata   = 8'h0;
        bus_data_in = 8'h00;
        wait_n      = 1'b1;
        t_wait_n    = 1'b0;
        cur_exp     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'hFF);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'h0);
        check("rst_bus_data", 32'({bus_data_out, bus_data_oe}), 32'h0);
        check("rst_strobes", 32'({sltsl_n, merq_n, iorq_n, rd_n, wr_n}), 32'h1F);
        check("rst_busy", 32'(busy), 32'd0);

        // Memory write 5000h = 07h
        set_req(1'b0, 1'b1, 16'h5000, 8'h07, 8'h00, 8'd6, 8'd4, 8'd3);
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        check("busy_during_cycle", 32'(busy), 32'd1);
        wait_rsp();

        // I/O read 0010h, slot returns A5h
        bus_data_in = 8'hA5;
        set_req(1'b1, 1'b0, 16'h0010, 8'h00, 8'hA5, 8'd6, 8'd4, 8'd3);
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        wait_rsp();

        // Memory read 4000h, wait_n low for 10 clocks from acceptance;
        // data only becomes valid once WAIT is released.
        bus_data_in = 8'hEE;
        wait_n = 1'b0;
        set_req(1'b0, 1'b0, 16'h4000, 8'h00, 8'h3C, 8'd15, 8'd13, 8'd12);
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        wait_n = 1'b1;
        bus_data_in = 8'h3C;
        wait_rsp();

        // WAIT stuck low on the short-timeout instance: 4 EXTEND clocks.
        bus_data_in = 8'h5A;
        req_is_io = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h8000;
        t_req_valid = 1'b1;
        @(posedge clk);
        #1;
        t_req_valid = 1'b0;
        per = 0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            per++;
            if (t_rsp_valid) break;
            if (!t_rd_n) cnt++;
        end
        $display("rsp     timeout-instance rdata=%02h timeout=%0d period=%0d",
                 t_rsp_rdata, t_rsp_timeout, per);
        check("to_rsp_valid", 32'(t_rsp_valid), 32'd1);
        check("to_rd_clocks", 32'(cnt), 32'd7);
        check("to_latency", 32'(per), 32'd10);
        check("to_timeout", 32'(t_rsp_timeout), 32'd1);
        check("to_rdata", 32'(t_rsp_rdata), 32'hFF);
        check("to_strobes", 32'({t_sltsl_n, t_merq_n, t_iorq_n, t_rd_n, t_wr_n}), 32'h1F);

        // Reset during the strobe of a write to B000h
        set_req(1'b0, 1'b1, 16'hB000, 8'h3E, 8'h00, 8'd6, 8'd4, 8'd3);
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_wr_low", 32'(wr_n), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mr_strobes", 32'({sltsl_n, merq_n, iorq_n, rd_n, wr_n}), 32'h1F);
        check("mr_oe", 32'(bus_data_oe), 32'd0);
        check("mr_req_ready", 32'(req_ready), 32'd1);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        sb.delete();
        reset = 1'b0;
        nrsp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        check("mr_no_rsp", 32'(nrsp), 32'd0);

        // Back-to-back: write 7000h=01h then I/O read 11h, valid held high
        bus_data_in = 8'h5C;
        set_req(1'b0, 1'b1, 16'h7000, 8'h01, 8'h00, 8'd6, 8'd4, 8'd3);
        req_valid = 1'b1;
        wait_accept();
        set_req(1'b1, 1'b0, 16'h0011, 8'h00, 8'h5C, 8'd6, 8'd4, 8'd3);
        acc1 = acc_cyc;
        wait_accept();
        req_valid = 1'b0;
        check("b2b_accept_edge", 32'(acc_cyc), 32'(last_rsp_cyc + 1));
        check("b2b_gap", 32'(acc_cyc - acc1), 32'd6);
        wait_rsp();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/msx_bus_master.md
Name: msx_bus_master

Overview:
- Initiator side of the MSX cartridge slot bus; drives Z80-style memory and I/O cycles into a slot, with full cartridge decode and mapper logic on the far side.
- Converts single-beat valid/ready requests into timed SLTSL/MERQ/IORQ/RD/WR strobes, honours WAIT, and returns read data or a timeout flag.
- Bench/host side of the MSX-USB cartridge: used to exercise the CH376 port decode (10h/11h/20h/21h) and the SCC-style bank-switch writes (5000h/7000h/9000h/B000h) from our own FPGA host.

Parameters:
- SETUP_CYCLES, 1, clocks that address and selects are held before RD/WR asserts (1..15).
- STROBE_CYCLES, 3, minimum clocks RD_n/WR_n held low (1..15).
- HOLD_CYCLES, 1, clocks that address and write data are held after the strobe deasserts (1..15).
- WAIT_TIMEOUT, 255, maximum strobe-extension clocks while wait_n is low (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle; request accepted on clk edge when valid&&ready
- req_is_io  in  1  1 = I/O cycle (iorq_n), 0 = memory cycle (merq_n + sltsl_n)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  bus address; I/O cycles drive it unchanged
- req_wdata  in  8  write data
- rsp_valid  out  1  one-clock pulse, cycle finished
- rsp_rdata  out  8  read data; FFh on timeout; holds value until the next rsp_valid
- rsp_timeout  out  1  qualified by rsp_valid; WAIT timeout occurred
- bus_addr  out  16  slot address A15..A0
- bus_data_out  out  8  data to slot
- bus_data_oe  out  1  data bus driven by this block
- bus_data_in  in  8  data from slot
- sltsl_n  out  1  slot select, memory cycles only
- merq_n  out  1  memory request
- iorq_n  out  1  I/O request
- rd_n  out  1  read strobe
- wr_n  out  1  write strobe
- wait_n  in  1  asynchronous wait from slot
- busy  out  1  not idle

Behaviour:
- All outputs are registered. Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=FFh, rsp_timeout=0.
  - bus_addr=0000h, bus_data_out=00h, bus_data_oe=0.
  - sltsl_n=merq_n=iorq_n=rd_n=wr_n=1, busy=0, state IDLE.
- wait_n passes through a 2-flop synchronizer (wait_s); the synchronizer resets to 1.
- States: IDLE -> SETUP -> STROBE -> (EXTEND) -> HOLD -> IDLE. A 4-bit phase counter and an 8-bit wait counter, both cleared on every state entry.
- IDLE:
  - req_ready=1.
  - Acceptance edge E0: latch all req fields, go to SETUP, req_ready=0, busy=1.
- SETUP (SETUP_CYCLES clocks):
  - bus_addr valid.
  - Memory cycle: merq_n=0, sltsl_n=0. I/O cycle: iorq_n=0.
  - Write cycle: bus_data_oe=1, bus_data_out=wdata.
  - rd_n=wr_n=1.
- STROBE (STROBE_CYCLES clocks): selects held; rd_n=0 for reads, wr_n=0 for writes.
- Leaving STROBE:
  - If wait_s=0 on the last STROBE clock, enter EXTEND. Strobes and selects are held.
  - EXTEND lasts until the first clock with wait_s=1, or until the wait counter reaches WAIT_TIMEOUT. The timeout sets an internal timeout flag.
- Leaving STROBE/EXTEND on the same edge:
  - Reads sample bus_data_in into rsp_rdata; on timeout rsp_rdata=FFh.
  - rd_n, wr_n, iorq_n, merq_n and sltsl_n all return to 1.
- HOLD (HOLD_CYCLES clocks): bus_addr held; writes keep bus_data_oe=1.
- End of HOLD:
  - bus_data_oe=0, state IDLE, busy=0, req_ready=1.
  - rsp_valid=1 for exactly that one clock; rsp_timeout=flag.
- Latency with no wait: rsp_valid is high in clock period SETUP+STROBE+HOLD+1 after E0. Defaults give 6.
- Back-to-back: a new request may be accepted on the same edge that ends the rsp_valid period. This gives at least one idle clock with all strobes high between cycles.
- req fields are ignored while req_ready=0.
- Reset mid-cycle: next clock returns to the reset values above. No rsp_valid is issued and strobes deassert immediately.
- A wait_s transition during SETUP or the first STROBE_CYCLES-1 strobe clocks has no effect; only the last strobe clock is checked.
- WAIT_TIMEOUT=255 with wait_n stuck low: exactly 255 EXTEND clocks, then rsp_timeout=1, rsp_rdata=FFh.

Test Plan:
- Memory write, addr 5000h, data 07h, defaults:
  - sltsl_n and merq_n low for 4 clocks; wr_n low for 3 clocks starting 1 clock after the selects.
  - bus_data_oe high for 5 clocks; rsp_valid in period 6, rsp_timeout=0.
- I/O read, addr 0010h, bus_data_in=A5h:
  - iorq_n low, sltsl_n stays 1, rd_n low 3 clocks.
  - rsp_rdata=A5h with rsp_valid in period 6; bus_data_oe never 1.
- Memory read 4000h with wait_n held low for 10 clocks from E0:
  - rd_n stretched (the synchronizer adds 2 clocks of latency to wait_n release).
  - rsp_rdata sampled only after wait_s=1; rsp_timeout=0.
- wait_n stuck low, WAIT_TIMEOUT=4: exactly 4 EXTEND clocks; rsp_timeout=1, rsp_rdata=FFh, strobes released.
- reset asserted during the STROBE of a write to B000h: next clock all strobes=1, bus_data_oe=0, req_ready=1, and no rsp_valid pulse.
- Two back-to-back requests (write 7000h=01h, then I/O read 11h) with req_valid held high:
  - Second accepted on the edge of the first rsp_valid; at least one idle clock with all strobes high between cycles.
  - Both responses correct.
